fsm_send_logic: RTL and testbench

- Downstream neighbour of the median-filter fill FSM.
- When the fill side raises up_next, this block snapshots the filled temporary window buffer into a shadow register. It then streams the window word by word to the median core over a valid/ready handshake.
- While busy it drives sending, which holds the fill FSM in WAIT until this block frees up.
- It also counts completed windows and flags protocol overruns.

---
 rtl/fsm_send_logic.sv | 113 +++++++++++
 tb/tb_fsm_send_logic.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_send_logic.sv
// fsm_send_logic: snapshots a filled window buffer when the fill FSM asks,
// then streams it word by word to the median core over valid/ready.
// Also counts completed windows and flags requests that arrive while busy.
module fsm_send_logic #(
  parameter int DATA_W = 8,
  parameter int WORDS  = 9,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    up_next,
  input  logic [DATA_W*WORDS-1:0] tmp_data,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    sending,
  output logic                    send_done,
  output logic [CNT_W-1:0]        win_cnt,
  output logic                    ovr_err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              load;
  logic [DATA_W-1:0] shadow [WORDS];

  // State, word index, window counter and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      win_cnt <= '0;
      ovr_err <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (state == DONE)
        win_cnt <= win_cnt + 1'b1;
      if (up_next && (state != IDLE))
        ovr_err <= 1'b1;
    end
  end

  // Shadow copy of the window; deliberately has no reset value.
  always_ff @(posedge clk) begin
    if (rst_n && load) begin
      for (int unsigned i = 0; i < WORDS; i++)
        shadow[i] <= tmp_data[i*DATA_W +: DATA_W];
    end
  end

  // Next-state and index update; unused state code recovers to IDLE.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (up_next) begin
          load      = 1'b1;
          idx_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx == LAST_IDX)
            state_nxt = DONE;
          else
            idx_nxt = idx + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode from registered state only, so out_ready never reaches out_valid.
  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    send_done = 1'b0;
    sending   = (state != IDLE);
    case (state)
      SEND: begin
        out_valid = 1'b1;
        out_data  = shadow[idx];
        out_last  = (idx == LAST_IDX);
      end
      DONE: begin
        send_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fsm_send_logic.sv
// Directed testbench for fsm_send_logic: nominal streaming, backpressure,
// snapshot isolation, overrun, mid-transfer reset and counter wrap.
module tb_fsm_send_logic;

  localparam int DW = 8;
  localparam int NW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          up_next;
  logic [DW*NW-1:0] tmp_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          sending;
  logic          send_done;
  logic [15:0]   win_cnt;
  logic          ovr_err;

  // Second instance with a 2-bit counter for the wrap test.
  logic          up_next2;
  logic [DW*NW-1:0] tmp_data2;
  logic [DW-1:0] out_data2;
  logic          out_valid2;
  logic          out_ready2;
  logic          out_last2;
  logic          sending2;
  logic          send_done2;
  logic [1:0]    win_cnt2;
  logic          ovr_err2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fsm_send_logic #(.DATA_W(DW), .WORDS(NW), .IDX_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .up_next(up_next), .tmp_data(tmp_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .sending(sending), .send_done(send_done),
    .win_cnt(win_cnt), .ovr_err(ovr_err)
  );

  fsm_send_logic #(.DATA_W(DW), .WORDS(NW), .IDX_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .up_next(up_next2), .tmp_data(tmp_data2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_last(out_last2), .sending(sending2), .send_done(send_done2),
    .win_cnt(win_cnt2), .ovr_err(ovr_err2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_window(input logic [7:0] base);
    for (int i = 0; i < NW; i++) tmp_data[i*DW +: DW] = 8'(base + i);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; up_next = 1'b0; out_ready = 1'b1; tmp_data = '0;
    up_next2 = 1'b0; out_ready2 = 1'b1; tmp_data2 = '0;
    step(); step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", out_data); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b exp 0", out_last); end
    n_checks++; if (sending !== 1'b0) begin n_fail++; $display("FAIL reset_sending got %b exp 0", sending); end
    n_checks++; if (send_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", send_done); end
    n_checks++; if (win_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_wincnt got %0d exp 0", win_cnt); end
    n_checks++; if (ovr_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got %b exp 0", ovr_err); end
    rst_n = 1'b1;
    step();
    n_checks++; if (sending !== 1'b0) begin n_fail++; $display("FAIL idle_sending got %b exp 0", sending); end
  endtask

  task automatic test_nominal();
    int occ;
    occ = 0;
    set_window(8'h10); out_ready = 1'b1; up_next = 1'b1;
    step();
    up_next = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (sending) occ++;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL nom_valid[%0d] got %b exp 1", i, out_valid); end
      n_checks++; if (out_data !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL nom_data[%0d] got %h exp %h", i, out_data, 8'(8'h10 + i)); end
      n_checks++; if (out_last !== (i == NW-1)) begin n_fail++; $display("FAIL nom_last[%0d] got %b exp %b", i, out_last, (i == NW-1)); end
      n_checks++; if (send_done !== 1'b0) begin n_fail++; $display("FAIL nom_early_done[%0d] got %b exp 0", i, send_done); end
      step();
    end
    if (sending) occ++;
    n_checks++; if (send_done !== 1'b1) begin n_fail++; $display("FAIL nom_done got %b exp 1", send_done); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nom_done_valid got %b exp 0", out_valid); end
    n_checks++; if (win_cnt !== 16'd0) begin n_fail++; $display("FAIL nom_cnt_in_done got %0d exp 0", win_cnt); end
    step();
    n_checks++; if (occ !== 10) begin n_fail++; $display("FAIL nom_occupancy got %0d exp 10", occ); end
    n_checks++; if (sending !== 1'b0) begin n_fail++; $display("FAIL nom_sending_drop got %b exp 0", sending); end
    n_checks++; if (send_done !== 1'b0) begin n_fail++; $display("FAIL nom_done_pulse got %b exp 0", send_done); end
    n_checks++; if (win_cnt !== 16'd1) begin n_fail++; $display("FAIL nom_wincnt got %0d exp 1", win_cnt); end
  endtask

  task automatic test_backpressure();
    int e, stall, occ, held;
    e = 0; stall = 0; occ = 0; held = 0;
    set_window(8'h10); out_ready = 1'b1; up_next = 1'b1;
    step();
    up_next = 1'b0;
    for (int c = 0; c < 30 && sending; c++) begin
      occ++;
      if (out_valid) begin
        n_checks++; if (out_data !== 8'(8'h10 + e)) begin n_fail++; $display("FAIL bp_data[%0d] got %h exp %h", c, out_data, 8'(8'h10 + e)); end
        n_checks++; if (out_last !== (e == NW-1)) begin n_fail++; $display("FAIL bp_last[%0d] got %b exp %b", c, out_last, (e == NW-1)); end
        if (out_data == 8'h14) held++;
        if (e == 4 && stall < 3) begin out_ready = 1'b0; stall++; end
        else out_ready = 1'b1;
        if (out_ready) e++;
      end else begin
        out_ready = 1'b1;
      end
      step();
    end
    out_ready = 1'b1;
    n_checks++; if (occ !== 13) begin n_fail++; $display("FAIL bp_occupancy got %0d exp 13", occ); end
    n_checks++; if (held !== 4) begin n_fail++; $display("FAIL bp_hold got %0d exp 4", held); end
    n_checks++; if (e !== NW) begin n_fail++; $display("FAIL bp_words got %0d exp %0d", e, NW); end
    n_checks++; if (win_cnt !== 16'd2) begin n_fail++; $display("FAIL bp_wincnt got %0d exp 2", win_cnt); end
  endtask

  task automatic test_snapshot();
    set_window(8'h10); out_ready = 1'b1; up_next = 1'b1;
    step();
    up_next = 1'b0;
    tmp_data = '1;
    for (int i = 0; i < NW; i++) begin
      n_checks++; if (out_data !== 8'(8'h10 + i) || out_valid !== 1'b1) begin n_fail++; $display("FAIL snap_data[%0d] got %h/%b exp %h/1", i, out_data, out_valid, 8'(8'h10 + i)); end
      step();
    end
    step();
    n_checks++; if (win_cnt !== 16'd3) begin n_fail++; $display("FAIL snap_wincnt got %0d exp 3", win_cnt); end
  endtask

  task automatic test_overrun();
    set_window(8'h10); out_ready = 1'b1; up_next = 1'b1;
    step();
    up_next = 1'b0;
    for (int i = 0; i < NW; i++) begin
      n_checks++; if (out_data !== 8'(8'h10 + i) || out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_data[%0d] got %h/%b exp %h/1", i, out_data, out_valid, 8'(8'h10 + i)); end
      if (i > 5) begin
        n_checks++; if (ovr_err !== 1'b1) begin n_fail++; $display("FAIL ovr_flag[%0d] got %b exp 1", i, ovr_err); end
      end
      if (i == 5) begin up_next = 1'b1; set_window(8'hA0); end
      else up_next = 1'b0;
      step();
    end
    up_next = 1'b0;
    n_checks++; if (send_done !== 1'b1) begin n_fail++; $display("FAIL ovr_done got %b exp 1", send_done); end
    step(); step(); step();
    n_checks++; if (sending !== 1'b0) begin n_fail++; $display("FAIL ovr_no_restart got %b exp 0", sending); end
    n_checks++; if (win_cnt !== 16'd4) begin n_fail++; $display("FAIL ovr_wincnt got %0d exp 4", win_cnt); end
    n_checks++; if (ovr_err !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got %b exp 1", ovr_err); end
  endtask

  task automatic test_reset_mid();
    set_window(8'h10); out_ready = 1'b1; up_next = 1'b1;
    step();
    up_next = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_checks++; if (out_data !== 8'h13) begin n_fail++; $display("FAIL rmid_pre got %h exp 13", out_data); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
    n_checks++; if (sending !== 1'b0) begin n_fail++; $display("FAIL rmid_sending got %b exp 0", sending); end
    n_checks++; if (win_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_wincnt got %0d exp 0", win_cnt); end
    n_checks++; if (ovr_err !== 1'b0) begin n_fail++; $display("FAIL rmid_ovr got %b exp 0", ovr_err); end
    n_checks++; if (send_done !== 1'b0) begin n_fail++; $display("FAIL rmid_done got %b exp 0", send_done); end
    step();
    n_checks++; if (send_done !== 1'b0 || sending !== 1'b0) begin n_fail++; $display("FAIL rmid_idle got %b/%b exp 0/0", send_done, sending); end
    set_window(8'h50); up_next = 1'b1;
    step();
    up_next = 1'b0;
    for (int i = 0; i < NW; i++) begin
      n_checks++; if (out_data !== 8'(8'h50 + i) || out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_new[%0d] got %h/%b exp %h/1", i, out_data, out_valid, 8'(8'h50 + i)); end
      step();
    end
    step();
    n_checks++; if (win_cnt !== 16'd1) begin n_fail++; $display("FAIL rmid_wincnt_new got %0d exp 1", win_cnt); end
  endtask

  task automatic test_done_collision();
    set_window(8'h60); out_ready = 1'b1; up_next = 1'b1;
    step();
    up_next = 1'b0;
    for (int i = 0; i < NW; i++) step();
    n_checks++; if (send_done !== 1'b1) begin n_fail++; $display("FAIL coll_done got %b exp 1", send_done); end
    up_next = 1'b1;
    step();
    up_next = 1'b0;
    n_checks++; if (ovr_err !== 1'b1) begin n_fail++; $display("FAIL coll_ovr got %b exp 1", ovr_err); end
    n_checks++; if (sending !== 1'b0) begin n_fail++; $display("FAIL coll_sending got %b exp 0", sending); end
    n_checks++; if (win_cnt !== 16'd2) begin n_fail++; $display("FAIL coll_wincnt got %0d exp 2", win_cnt); end
  endtask

  task automatic test_back_to_back();
    out_ready2 = 1'b1;
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < NW; i++) tmp_data2[i*DW +: DW] = 8'(8'h30 + 16*w + i);
      up_next2 = 1'b1;
      step();
      up_next2 = 1'b0;
      for (int i = 0; i < NW; i++) begin
        n_checks++; if (out_data2 !== 8'(8'h30 + 16*w + i) || out_valid2 !== 1'b1) begin n_fail++; $display("FAIL b2b_data[%0d][%0d] got %h/%b exp %h/1", w, i, out_data2, out_valid2, 8'(8'h30 + 16*w + i)); end
        step();
      end
      n_checks++; if (send_done2 !== 1'b1) begin n_fail++; $display("FAIL b2b_done[%0d] got %b exp 1", w, send_done2); end
      step();
      n_checks++; if (win_cnt2 !== 2'((w + 1) % 4)) begin n_fail++; $display("FAIL b2b_wincnt[%0d] got %0d exp %0d", w, win_cnt2, (w + 1) % 4); end
    end
    n_checks++; if (ovr_err2 !== 1'b0) begin n_fail++; $display("FAIL b2b_ovr got %b exp 0", ovr_err2); end
    n_checks++; if (sending2 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b exp 0", sending2); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_snapshot();
    test_overrun();
    test_reset_mid();
    test_done_collision();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
